// File: rtl/stpw_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stpw_pkg - field widths, moduli and mode encoding for stopwatch  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package stpw_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int LAP_W  = HOUR_W + MIN_W + SEC_W + MSEC_W;

  localparam int MSEC_MAX = 100;
  localparam int SEC_MAX  = 60;
  localparam int MIN_MAX  = 60;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  function automatic logic [5:0] clamp_60(input logic [5:0] v);
    return (v >= 6'(SEC_MAX)) ? 6'(SEC_MAX - 1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stpw_updn_digit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stpw_updn_digit - modulus-MOD up/down digit with load and carry  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module stpw_updn_digit #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         tick_in,
  input  logic         down,
  output logic [W-1:0] val,
  output logic         co
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (load) begin
      val_d = ld_val;
    end else if (tick_in) begin
      if (down) begin
        val_d = (val_q == '0) ? TOP : (val_q - ONE);
      end else begin
        val_d = (val_q == TOP) ? '0 : (val_q + ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  // Carry (up) or borrow (down) is raised in the same cycle as the incoming tick.
  assign co  = tick_in & (down ? (val_q == '0) : (val_q == TOP));
  assign val = val_q;

endmodule
`default_nettype wire

// File: rtl/stpw_lap_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stpw_lap_datapath - up/down stopwatch/timer with lap FIFO;       |
// | lap buffer built only with macro STPW_LAP_EN. rev 1.0            |
// +------------------------------------------------------------------+
module stpw_lap_datapath
  import stpw_pkg::*;
#(
  parameter int DIV_MSEC  = 1_000_000,
  parameter int HOUR_MAX  = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         run,
  input  logic                         mode,
  input  logic                         load,
  input  logic [HOUR_W-1:0]            ld_hour,
  input  logic [MIN_W-1:0]             ld_min,
  input  logic [SEC_W-1:0]             ld_sec,
  output logic [MSEC_W-1:0]            msec,
  output logic [SEC_W-1:0]             sec,
  output logic [MIN_W-1:0]             min,
  output logic [HOUR_W-1:0]            hour,
  output logic                         done,
  output logic                         wrap,
  input  logic                         lap,
  input  logic                         lap_pop,
  output logic                         lap_valid,
  output logic [LAP_W-1:0]             lap_time,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
  output logic                         lap_ovf
);

  localparam int               DIV_W   = $clog2(DIV_MSEC);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DIV_MSEC - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              tick_w, tick_eff_w, down_w, zero_w, one_w;
  logic              msec_co, sec_co, min_co, hour_co;
  logic [HOUR_W-1:0] ld_hour_w;
  logic [LAP_W-1:0]  time_w;

  assign down_w    = (mode_e'(mode) == MODE_DOWN);
  assign tick_w    = run & (div_q == DIV_TOP);
  assign time_w    = {hour, min, sec, msec};
  assign zero_w    = (time_w == '0);
  assign one_w     = (time_w == LAP_W'(1));
  // A countdown parked at zero swallows ticks so no borrow can reach the hour digit.
  assign tick_eff_w = tick_w & ~(down_w & zero_w);
  assign ld_hour_w = ({1'b0, ld_hour} >= 6'(HOUR_MAX)) ? HOUR_W'(HOUR_MAX - 1) : ld_hour;

  always_comb begin
    div_d  = div_q;
    done_d = done_q;
    wrap_d = 1'b0;
    if (clr || load) begin
      div_d  = '0;
      done_d = 1'b0;
    end else begin
      if (run) begin
        div_d = tick_w ? '0 : (div_q + DIV_ONE);
      end
      if (tick_w && down_w && (zero_w || one_w)) begin
        done_d = 1'b1;
      end
      wrap_d = tick_eff_w & ~down_w & hour_co;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign done = done_q;
  assign wrap = wrap_q;

  stpw_updn_digit #(.MOD(MSEC_MAX), .W(MSEC_W)) u_msec (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val({MSEC_W{1'b0}}),
    .tick_in(tick_eff_w), .down(down_w), .val(msec), .co(msec_co)
  );

  stpw_updn_digit #(.MOD(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(clamp_60(ld_sec)),
    .tick_in(msec_co), .down(down_w), .val(sec), .co(sec_co)
  );

  stpw_updn_digit #(.MOD(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(clamp_60(ld_min)),
    .tick_in(sec_co), .down(down_w), .val(min), .co(min_co)
  );

  stpw_updn_digit #(.MOD(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(ld_hour_w),
    .tick_in(min_co), .down(down_w), .val(hour), .co(hour_co)
  );

`ifdef STPW_LAP_EN
  localparam int              AW       = $clog2(LAP_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(LAP_DEPTH);

  logic [LAP_W-1:0] mem_q [LAP_DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push_w, pop_w;

  always_comb begin
    pop_w  = lap_pop & (cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    push_w = lap & ((cnt_q != CNT_FULL) | pop_w);
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop_w)  rd_d = rd_q + PTR_ONE;
      if (push_w) wr_d = wr_q + PTR_ONE;
      if (push_w && !pop_w) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop_w && !push_w) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      if (lap && !push_w) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w && !clr) begin
      mem_q[wr_q] <= time_w;
    end
  end

  assign lap_valid = (cnt_q != '0);
  assign lap_time  = lap_valid ? mem_q[rd_q] : '0;
  assign lap_cnt   = cnt_q;
  assign lap_ovf   = ovf_q;
`else
  logic unused_lap;
  assign unused_lap = lap ^ lap_pop;
  assign lap_valid  = 1'b0;
  assign lap_time   = '0;
  assign lap_cnt    = '0;
  assign lap_ovf    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stpw_lap_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stpw_lap_datapath - randomized and directed bench with a      |
// | hundredths-of-a-second reference model. rev 1.0                  |
// +------------------------------------------------------------------+
module tb_stpw_lap_datapath;

  localparam int DIV   = 2;
  localparam int HM    = 24;
  localparam int LD    = 4;
  localparam int TOTAL = HM * 360000;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, run = 1'b0, mode = 1'b0, load = 1'b0;
  logic lap = 1'b0, lap_pop = 1'b0;
  logic [4:0] ld_hour = '0;
  logic [5:0] ld_min = '0, ld_sec = '0;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic done, wrap, lap_valid, lap_ovf;
  logic [23:0] lap_time;
  logic [2:0] lap_cnt;
  logic [23:0] now;

  int tests = 0;
  int fails = 0;

  // reference model state: time as total hundredths since 0:00:00.00
  int m_t, m_div;
  bit m_done, m_wrap, m_ovf;
  logic [23:0] m_q[$];

  assign now = {hour, min, sec, msec};

  stpw_lap_datapath #(.DIV_MSEC(DIV), .HOUR_MAX(HM), .LAP_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .clr(clr), .run(run), .mode(mode), .load(load),
    .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
    .msec(msec), .sec(sec), .min(min), .hour(hour), .done(done), .wrap(wrap),
    .lap(lap), .lap_pop(lap_pop), .lap_valid(lap_valid), .lap_time(lap_time),
    .lap_cnt(lap_cnt), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int t);
    logic [4:0] h;
    logic [5:0] m, s;
    logic [6:0] c;
    h = 5'(t / 360000);
    m = 6'((t / 6000) % 60);
    s = 6'((t / 100) % 60);
    c = 7'(t % 100);
    return {h, m, s, c};
  endfunction

  function automatic void model_reset();
    m_t = 0; m_div = 0; m_done = 0; m_wrap = 0; m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit tick, pop, full;
    int ch, cm, cs;
    tick = run && (m_div == DIV - 1);
`ifdef STPW_LAP_EN
    if (clr) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      pop  = lap_pop && (m_q.size() > 0);
      full = (m_q.size() == LD);
      if (pop) void'(m_q.pop_front());
      if (lap) begin
        if (!full || pop) m_q.push_back(pack(m_t));
        else m_ovf = 1;
      end
    end
`else
    pop = 0; full = 0;
`endif
    m_wrap = 0;
    if (clr) begin
      m_t = 0; m_div = 0; m_done = 0;
    end else if (load) begin
      ch = (int'(ld_hour) >= HM) ? HM - 1 : int'(ld_hour);
      cm = (int'(ld_min) >= 60) ? 59 : int'(ld_min);
      cs = (int'(ld_sec) >= 60) ? 59 : int'(ld_sec);
      m_t = ch * 360000 + cm * 6000 + cs * 100;
      m_div = 0; m_done = 0;
    end else begin
      if (run) m_div = tick ? 0 : m_div + 1;
      if (tick) begin
        if (!mode) begin
          if (m_t == TOTAL - 1) begin m_t = 0; m_wrap = 1; end
          else m_t = m_t + 1;
        end else begin
          if (m_t <= 1) begin m_t = 0; m_done = 1; end
          else m_t = m_t - 1;
        end
      end
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic align_tick();
    for (int k = 0; k < DIV && m_div != DIV - 1; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (now !== 24'h0 || done !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL reset_time got=%h done=%b wrap=%b want 0", now, done, wrap);
    end
    tests++;
    if (lap_valid !== 1'b0 || lap_cnt !== 3'd0 || lap_ovf !== 1'b0 || lap_time !== 24'h0) begin
      fails++; $display("FAIL reset_lap got v=%b c=%0d o=%b t=%h want 0", lap_valid, lap_cnt, lap_ovf, lap_time);
    end
    model_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic test_up_rollover();
    int wc;
    clr = 1; step(); clr = 0;
    mode = 0; ld_hour = 5'd31; ld_min = 6'd63; ld_sec = 6'd63;
    load = 1; step(); load = 0;
    tests++;
    if (now !== {5'd23, 6'd59, 6'd59, 7'd0}) begin
      fails++; $display("FAIL load_clamp got=%h want=%h", now, {5'd23, 6'd59, 6'd59, 7'd0});
    end
    run = 1; wc = 0;
    for (int i = 0; i < 199; i++) begin step(); if (wrap === 1'b1) wc++; end
    tests++;
    if (now !== {5'd23, 6'd59, 6'd59, 7'd99} || wc != 0) begin
      fails++; $display("FAIL up_pre_wrap got=%h wraps=%0d want=%h wraps=0", now, wc, {5'd23, 6'd59, 6'd59, 7'd99});
    end
    step(); if (wrap === 1'b1) wc++;
    tests++;
    if (now !== 24'h0 || wrap !== 1'b1) begin
      fails++; $display("FAIL up_wrap got=%h wrap=%b want 0 wrap=1", now, wrap);
    end
    for (int i = 0; i < 4; i++) begin step(); if (wrap === 1'b1) wc++; end
    tests++;
    if (wc != 1 || now !== {5'd0, 6'd0, 6'd0, 7'd2}) begin
      fails++; $display("FAIL up_wrap_once wraps=%0d time=%h want wraps=1 time=%h", wc, now, {5'd0, 6'd0, 6'd0, 7'd2});
    end
    run = 0;
  endtask

  task automatic test_countdown();
    ld_hour = 0; ld_min = 0; ld_sec = 1; mode = 1;
    load = 1; step(); load = 0;
    run = 1;
    for (int i = 0; i < 198; i++) step();
    tests++;
    if (now !== 24'd1 || done !== 1'b0) begin
      fails++; $display("FAIL down_pre_zero got=%h done=%b want=000001 done=0", now, done);
    end
    step(); step();
    tests++;
    if (now !== 24'h0 || done !== 1'b1) begin
      fails++; $display("FAIL down_zero got=%h done=%b want 0 done=1", now, done);
    end
    for (int i = 0; i < 20; i++) step();
    tests++;
    if (now !== 24'h0 || done !== 1'b1) begin
      fails++; $display("FAIL down_hold got=%h done=%b want 0 done=1", now, done);
    end
    run = 0;
  endtask

  task automatic test_done_at_zero();
    clr = 1; step(); clr = 0;
    mode = 1; run = 1;
    step();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_early got=%b want 0", done); end
    step();
    tests++;
    if (done !== 1'b1 || now !== 24'h0) begin
      fails++; $display("FAIL zero_done got=%b time=%h want done=1 time=0", done, now);
    end
    run = 0;
  endtask

  task automatic test_priority();
    clr = 1; step(); clr = 0;
    mode = 1; run = 1;
    step(); step();
    lap = 1; step(); lap = 0;
    align_tick();
    ld_hour = 5; ld_min = 6; ld_sec = 7;
    clr = 1; load = 1; step(); clr = 0; load = 0;
    tests++;
    if (now !== 24'h0 || done !== 1'b0 || lap_cnt !== 3'd0 || lap_valid !== 1'b0) begin
      fails++; $display("FAIL prio_clr got=%h done=%b cnt=%0d want 0", now, done, lap_cnt);
    end
    step(); step();
    align_tick();
    load = 1; step(); load = 0;
    tests++;
    if (now !== {5'd5, 6'd6, 6'd7, 7'd0} || done !== 1'b0) begin
      fails++; $display("FAIL prio_load got=%h done=%b want=%h", now, done, {5'd5, 6'd6, 6'd7, 7'd0});
    end
    step();
    tests++;
    if (now !== {5'd5, 6'd6, 6'd7, 7'd0}) begin
      fails++; $display("FAIL prio_div_reset got=%h want=%h", now, {5'd5, 6'd6, 6'd7, 7'd0});
    end
    step();
    tests++;
    if (now !== {5'd5, 6'd6, 6'd6, 7'd99}) begin
      fails++; $display("FAIL down_borrow got=%h want=%h", now, {5'd5, 6'd6, 6'd6, 7'd99});
    end
    run = 0;
  endtask

`ifdef STPW_LAP_EN
  task automatic test_lap_overflow();
    logic [23:0] cap [5];
    clr = 1; step(); clr = 0;
    mode = 0; run = 1;
    for (int i = 0; i < 5; i++) begin
      step(); step(); step();
      cap[i] = pack(m_t);
      lap = 1; step(); lap = 0;
    end
    tests++;
    if (lap_cnt !== 3'd4 || lap_ovf !== 1'b1 || lap_valid !== 1'b1) begin
      fails++; $display("FAIL lap_ovf cnt=%0d ovf=%b want cnt=4 ovf=1", lap_cnt, lap_ovf);
    end
    run = 0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (lap_time !== cap[i]) begin
        fails++; $display("FAIL lap_order[%0d] got=%h want=%h", i, lap_time, cap[i]);
      end
      lap_pop = 1; step(); lap_pop = 0;
    end
    lap_pop = 1; step(); lap_pop = 0;
    tests++;
    if (lap_valid !== 1'b0 || lap_cnt !== 3'd0 || lap_time !== 24'h0 || lap_ovf !== 1'b1) begin
      fails++; $display("FAIL lap_empty v=%b cnt=%0d t=%h ovf=%b want 0/0/0/1", lap_valid, lap_cnt, lap_time, lap_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    logic [23:0] cap [4];
    logic [23:0] last;
    clr = 1; step(); clr = 0;
    tests++;
    if (lap_ovf !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%b want 0", lap_ovf); end
    run = 1;
    for (int i = 0; i < 4; i++) begin
      step(); step();
      cap[i] = pack(m_t);
      lap = 1; step(); lap = 0;
    end
    step(); step(); step();
    last = pack(m_t);
    lap = 1; lap_pop = 1; step(); lap = 0; lap_pop = 0;
    run = 0;
    tests++;
    if (lap_cnt !== 3'd4 || lap_time !== cap[1] || lap_ovf !== 1'b0) begin
      fails++; $display("FAIL push_pop_full cnt=%0d head=%h ovf=%b want cnt=4 head=%h ovf=0", lap_cnt, lap_time, lap_ovf, cap[1]);
    end
    for (int i = 0; i < 3; i++) begin lap_pop = 1; step(); lap_pop = 0; end
    tests++;
    if (lap_time !== last || lap_cnt !== 3'd1) begin
      fails++; $display("FAIL push_pop_newest got=%h cnt=%0d want=%h cnt=1", lap_time, lap_cnt, last);
    end
  endtask
`else
  task automatic test_lap_disabled();
    run = 1;
    for (int i = 0; i < 6; i++) begin lap = 1; lap_pop = (i == 3); step(); end
    lap = 0; lap_pop = 0; run = 0;
    tests++;
    if (lap_valid !== 1'b0 || lap_cnt !== 3'd0 || lap_ovf !== 1'b0 || lap_time !== 24'h0) begin
      fails++; $display("FAIL lap_disabled v=%b cnt=%0d o=%b t=%h want 0", lap_valid, lap_cnt, lap_ovf, lap_time);
    end
  endtask
`endif

  task automatic test_random();
    logic [23:0] head;
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ld_hour = 5'($urandom_range(0, 31)); ld_min = 6'($urandom_range(0, 63)); ld_sec = 6'($urandom_range(0, 63));
      end else begin
        ld_hour = 0; ld_min = 0; ld_sec = 6'($urandom_range(0, 1));
      end
      run = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      lap     = ($urandom_range(0, 5) == 0);
      lap_pop = ($urandom_range(0, 5) == 0);
      step();
      head = (m_q.size() != 0) ? m_q[0] : 24'h0;
      tests++;
      if (now !== pack(m_t)) begin
        fails++; $display("FAIL rand_time cyc=%0d got=%h want=%h", i, now, pack(m_t));
      end
      tests++;
      if (done !== m_done || wrap !== m_wrap) begin
        fails++; $display("FAIL rand_flags cyc=%0d done=%b wrap=%b want %b %b", i, done, wrap, m_done, m_wrap);
      end
      tests++;
      if (lap_cnt !== 3'(m_q.size()) || lap_valid !== (m_q.size() != 0) || lap_ovf !== m_ovf) begin
        fails++; $display("FAIL rand_lapstat cyc=%0d cnt=%0d ovf=%b want %0d %b", i, lap_cnt, lap_ovf, m_q.size(), m_ovf);
      end
      tests++;
      if (lap_time !== head) begin
        fails++; $display("FAIL rand_laptime cyc=%0d got=%h want=%h", i, lap_time, head);
      end
    end
    clr = 0; load = 0; lap = 0; lap_pop = 0; run = 0;
  endtask

  task automatic test_reset_mid();
    clr = 1; step(); clr = 0;
    mode = 0; run = 1;
    for (int i = 0; i < 2468; i++) begin
      lap = (i == 100);
      step();
    end
    lap = 0;
    tests++;
    if (now !== {5'd0, 6'd0, 6'd12, 7'd34}) begin
      fails++; $display("FAIL mid_count got=%h want=%h", now, {5'd0, 6'd0, 6'd12, 7'd34});
    end
    rst = 1'b0;
    #1;
    tests++;
    if (now !== 24'h0 || done !== 1'b0 || wrap !== 1'b0 || lap_cnt !== 3'd0 || lap_valid !== 1'b0 ||
        lap_ovf !== 1'b0 || lap_time !== 24'h0) begin
      fails++; $display("FAIL async_reset time=%h done=%b cnt=%0d want all 0", now, done, lap_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(); step();
    tests++;
    if (now !== 24'd1) begin
      fails++; $display("FAIL restart got=%h want=000001", now);
    end
    run = 0;
  endtask

  initial begin
    test_reset();
    test_up_rollover();
    test_countdown();
    test_done_at_zero();
    test_priority();
`ifdef STPW_LAP_EN
    test_lap_overflow();
    test_push_pop_full();
`else
    test_lap_disabled();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stpw_lap_datapath.md
STPW_LAP_DATAPATH -- requirements
Module: stpw_lap_datapath

Interface
REQ-001 SHALL have parameter DIV_MSEC, default 1_000_000: clk cycles per 10 ms tick at 100 MHz; legal values are 2 and above.
REQ-002 SHALL have parameter HOUR_MAX, default 24: hour modulus; legal range is 2 to 32.
REQ-003 SHALL have parameter LAP_DEPTH, default 4: lap buffer entries; legal values are powers of two, 2 to 16.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous reset, active-low.
REQ-007 clr  in  1  synchronous clear of time, divider and done.
REQ-008 run  in  1  level; count enable.
REQ-009 mode  in  1  0 = count up (stopwatch), 1 = count down (timer).
REQ-010 load  in  1  pulse; loads ld_hour/ld_min/ld_sec and sets msec to 0.
REQ-011 ld_hour/ld_min/ld_sec  in  5/6/6  load values; out-of-range values are clamped to max-1.
REQ-012 msec/sec/min/hour  out  7/6/6/5  current time (msec counts hundredths, 0..99).
REQ-013 done  out  1  sticky; countdown has reached zero.
REQ-014 wrap  out  1  one-cycle pulse on up-count rollover.
REQ-015 lap  in  1  pulse; captures the current time into the buffer.
REQ-016 lap_pop  in  1  pulse; discards the head entry.
REQ-017 lap_valid  out  1  buffer is non-empty.
REQ-018 lap_time  out  24  head entry, packed as {hour,min,sec,msec}.
REQ-019 lap_cnt  out  $clog2(LAP_DEPTH)+1  number of occupancy entries.
REQ-020 lap_ovf  out  1  sticky; a capture was dropped.

Function
REQ-021 The divider SHALL count only while run=1 and SHALL emit a one-cycle tick every DIV_MSEC counting cycles; it SHALL hold its count while run=0.
REQ-022 Time outputs SHALL update on the clock edge following the cycle in which the tick is asserted (1-cycle latency).
REQ-023 Up mode: cascade msec 99→0 carries to sec, sec 59→0 to min, min 59→0 to hour; at HOUR_MAX-1:59:59.99 the next tick SHALL give all-zero time and pulse wrap.
REQ-024 Down mode: borrows SHALL propagate mirror-wise; on reaching 0:00:00.00, done SHALL be set and further ticks ignored; there SHALL be no wrap.
REQ-025 In down mode with time already zero and run=1, done SHALL set on the next tick.
REQ-026 Priority SHALL be clr > load > tick; clr and load SHALL each also reset the divider and clear done.
REQ-027 A mode change SHALL take effect on the next tick and SHALL NOT alter the time value.
REQ-028 lap SHALL push the registered time of that cycle, i.e. the pre-tick value if a tick coincides.
REQ-029 Lap buffer SHALL be a FIFO; lap_time SHALL be valid whenever lap_valid=1.
REQ-030 Push when full without a pop SHALL be dropped and SHALL set lap_ovf.
REQ-031 Simultaneous push and pop SHALL both occur, including when full; lap_cnt SHALL be unchanged.
REQ-032 Pop when empty SHALL be ignored.
REQ-033 clr SHALL empty the buffer and clear lap_ovf; load SHALL NOT affect the buffer.

Reset
REQ-034 On rst=0, all time outputs, divider, done, wrap, lap_cnt, lap_valid and lap_ovf SHALL be 0 immediately.
REQ-035 Buffer storage SHALL need no reset; lap_time SHALL read 0 while the buffer is empty.
REQ-036 Reset mid-count SHALL abort counting; counting SHALL restart from zero after release.

Configuration
REQ-037 Macro STPW_LAP_EN SHALL control the lap buffer.
REQ-038 With STPW_LAP_EN defined, the lap buffer SHALL be built as specified.
REQ-039 Without STPW_LAP_EN, the lap ports SHALL remain; lap_valid, lap_cnt, lap_ovf and lap_time SHALL tie to 0, and lap/lap_pop SHALL be ignored.

Structure
REQ-040 Package stpw_pkg SHALL hold the field widths (7/6/6/5), the packed lap-record width (24), the constants MSEC_MAX=100 and SEC_MAX=MIN_MAX=60, and the mode encoding.
REQ-041 Sub-module stpw_updn_digit SHALL provide a parametrised modulus up/down counter with load, clear, in-tick and carry/borrow-out; it SHALL be instantiated four times.

Verification (DIV_MSEC=2, HOUR_MAX=24, LAP_DEPTH=4)
REQ-042 Up rollover: load 23:59:59 with mode=0 and run=1 → after 100 ticks time=0:00:00.00 and wrap pulses exactly once.
REQ-043 Countdown: load 0:00:01, mode=1, run=1 → after 100 ticks time=0, done=1; later ticks leave time at 0.
REQ-044 Lap overflow: 5 laps at distinct times with no pop → lap_cnt=4, lap_ovf=1; 4 pops return the first 4 captures in order.
REQ-045 Lap push+pop while full: same-cycle lap and lap_pop → lap_cnt stays 4, head advances, newest entry equals the time at the lap cycle.
REQ-046 Priority: clr, load and tick in one cycle → time=0, done=0, buffer empty; load and tick together → loaded value with msec=0.
REQ-047 Reset: assert rst=0 mid-count at 0:00:12.34 → all outputs read 0 before the next clk edge.
